snake_move_scheduler: RTL and testbench

- Sequences snake motion and game state from the edge-detected input pulses: direction, start/pause button, good and bad collision.
- Buffers player direction requests in a small FIFO and rejects reversals.
- Applies at most one direction change per game tick and emits a one-cycle step strobe to the board/body logic.
- Owns the game state machine and the score counter.

---
 rtl/snake_move_scheduler.sv | 148 ++++++++++++++
 tb/tb_snake_move_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/snake_move_scheduler.sv
// Snake motion sequencer: buffers direction requests, applies at most one turn
// per game tick, and owns the game state machine and the food score.
module snake_move_scheduler #(
  parameter int QDEPTH  = 2,
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         dir_pulse,
  input  logic               button,
  input  logic               good_coll,
  input  logic               bad_coll,
  input  logic               tick,
  output logic [3:0]         cur_dir,
  output logic               step,
  output logic               grow,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] score,
  output logic               q_full
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0]      DEPTH_C   = CW'(QDEPTH);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [3:0]         DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         fifo_q [QDEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [3:0]         cur_dir_q, cur_dir_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               step_q, step_d;
  logic               grow_q, grow_d;
  logic               q_full_q, q_full_d;

  logic       in_run, game_start, game_kill, flush;
  logic       fifo_full, do_pop, do_push, dir_accept;
  logic [3:0] newest_dir, ref_dir, opposite_dir;

  assign in_run     = (state_q == ST_RUN);
  assign game_start = (state_q == ST_IDLE) && button;
  assign game_kill  = in_run && bad_coll;
  assign flush      = game_start || game_kill;
  assign fifo_full  = (count_q == DEPTH_C);

  // Turns are judged against the last direction the snake will have taken.
  assign newest_dir   = fifo_q[wr_ptr_q - 1'b1];
  assign ref_dir      = (count_q != '0) ? newest_dir : cur_dir_q;
  assign opposite_dir = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};

  assign dir_accept = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !game_kill
                    && $onehot(dir_pulse)
                    && (dir_pulse != ref_dir) && (dir_pulse != opposite_dir);
  assign do_pop  = in_run && !bad_coll && tick && (count_q != '0);
  assign do_push = dir_accept && (!fifo_full || do_pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (button) state_d = ST_RUN;
      ST_RUN: begin
        if (bad_coll)    state_d = ST_OVER;
        else if (button) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (button) state_d = ST_RUN;
      ST_OVER:  if (button) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
    q_full_d = (count_d == DEPTH_C);
  end

  always_comb begin
    cur_dir_d = cur_dir_q;
    score_d   = score_q;
    step_d    = in_run && !bad_coll && tick;
    grow_d    = in_run && !bad_coll && good_coll;
    if (game_start) begin
      cur_dir_d = DIR_RIGHT;
      score_d   = '0;
    end else begin
      if (do_pop) cur_dir_d = fifo_q[rd_ptr_q];
      if (grow_d && (score_q != SCORE_MAX)) score_d = score_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cur_dir_q <= DIR_RIGHT;
      score_q   <= '0;
      step_q    <= 1'b0;
      grow_q    <= 1'b0;
      q_full_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cur_dir_q <= cur_dir_d;
      score_q   <= score_d;
      step_q    <= step_d;
      grow_q    <= grow_d;
      q_full_q  <= q_full_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) fifo_q[wr_ptr_q] <= dir_pulse;
  end

  assign cur_dir    = cur_dir_q;
  assign step       = step_q;
  assign grow       = grow_q;
  assign game_state = state_q;
  assign score      = score_q;
  assign q_full     = q_full_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Directed bench: each step drives one cycle of inputs, queues the expected
// post-edge outputs, then pops and checks them just after the clock edge.
module tb_snake_move_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] dir_pulse = 4'b0;
  logic       button = 1'b0, good_coll = 1'b0, bad_coll = 1'b0, tick = 1'b0;

  logic [3:0] cur_dir;
  logic       step, grow, q_full;
  logic [1:0] game_state;
  logic [7:0] score;

  logic [3:0] cur_dir_b;
  logic       step_b, grow_b, q_full_b;
  logic [1:0] game_state_b;
  logic [1:0] score_b;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string      tag;
    logic [3:0] dir;
    logic       stp;
    logic       grw;
    logic [1:0] st;
    logic [7:0] sc;
    logic [1:0] sc2;
    logic       qf;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  snake_move_scheduler #(.QDEPTH(2), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .dir_pulse(dir_pulse), .button(button),
    .good_coll(good_coll), .bad_coll(bad_coll), .tick(tick),
    .cur_dir(cur_dir), .step(step), .grow(grow), .game_state(game_state),
    .score(score), .q_full(q_full)
  );

  snake_move_scheduler #(.QDEPTH(2), .SCORE_W(2)) dut_sat (
    .clk(clk), .rst(rst), .dir_pulse(dir_pulse), .button(button),
    .good_coll(good_coll), .bad_coll(bad_coll), .tick(tick),
    .cur_dir(cur_dir_b), .step(step_b), .grow(grow_b), .game_state(game_state_b),
    .score(score_b), .q_full(q_full_b)
  );

  task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp_v);
    end
  endtask

  task automatic check_head();
    exp_t e;
    e = sb_q.pop_front();
    chk(e.tag, "cur_dir",    8'(cur_dir),    8'(e.dir));
    chk(e.tag, "step",       8'(step),       8'(e.stp));
    chk(e.tag, "grow",       8'(grow),       8'(e.grw));
    chk(e.tag, "game_state", 8'(game_state), 8'(e.st));
    chk(e.tag, "score",      score,          e.sc);
    chk(e.tag, "score_sat",  8'(score_b),    8'(e.sc2));
    chk(e.tag, "q_full",     8'(q_full),     8'(e.qf));
    $display("[TB] %-10s dir=%b step=%b grow=%b st=%0d score=%0d score2=%0d q_full=%b",
             e.tag, cur_dir, step, grow, game_state, score, score_b, q_full);
  endtask

  task automatic cy(input string tag, input logic r, input logic [3:0] dp,
                    input logic b, input logic g, input logic bc, input logic t,
                    input logic [3:0] edir, input logic es, input logic eg,
                    input logic [1:0] est, input logic [7:0] esc,
                    input logic [1:0] esc2, input logic eqf);
    exp_t e;
    rst = r; dir_pulse = dp; button = b; good_coll = g; bad_coll = bc; tick = t;
    e = '{tag: tag, dir: edir, stp: es, grw: eg, st: est, sc: esc, sc2: esc2, qf: eqf};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; dir_pulse = 4'b0; button = 1'b0; good_coll = 1'b0; bad_coll = 1'b0; tick = 1'b0;
    check_head();
  endtask

  localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001, N = 4'b0000;

  initial begin
    //  tag           rst dp       btn gc bc tk   dir st gr state sc sc2 qf
    cy("reset0",      1, N,        0, 0, 0, 0,   R, 0, 0, 0, 0, 0, 0);
    cy("reset1",      1, N,        0, 0, 0, 0,   R, 0, 0, 0, 0, 0, 0);
    cy("idle_tick",   0, N,        0, 0, 0, 1,   R, 0, 0, 0, 0, 0, 0);
    cy("idle_good",   0, N,        0, 1, 0, 0,   R, 0, 0, 0, 0, 0, 0);
    cy("start",       0, N,        1, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    cy("tick1",       0, N,        0, 0, 0, 1,   R, 1, 0, 1, 0, 0, 0);
    cy("quiet1",      0, N,        0, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    // reversal dropped, perpendicular turn queued
    cy("rev_left",    0, L,        0, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    cy("push_up",     0, U,        0, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    cy("pop_up",      0, N,        0, 0, 0, 1,   U, 1, 0, 1, 0, 0, 0);
    cy("tick_same1",  0, N,        0, 0, 0, 1,   U, 1, 0, 1, 0, 0, 0);
    cy("tick_same2",  0, N,        0, 0, 0, 1,   U, 1, 0, 1, 0, 0, 0);
    cy("quiet2",      0, N,        0, 0, 0, 0,   U, 0, 0, 1, 0, 0, 0);
    // fill to capacity, overflow request dropped
    cy("fill_left",   0, L,        0, 0, 0, 0,   U, 0, 0, 1, 0, 0, 0);
    cy("fill_down",   0, D,        0, 0, 0, 0,   U, 0, 0, 1, 0, 0, 1);
    cy("ovf_right",   0, R,        0, 0, 0, 0,   U, 0, 0, 1, 0, 0, 1);
    cy("pop_left",    0, N,        0, 0, 0, 1,   L, 1, 0, 1, 0, 0, 0);
    cy("pop_down",    0, N,        0, 0, 0, 1,   D, 1, 0, 1, 0, 0, 0);
    cy("empty_tick",  0, N,        0, 0, 0, 1,   D, 1, 0, 1, 0, 0, 0);
    // push while full on a popping tick
    cy("refill_l",    0, L,        0, 0, 0, 0,   D, 0, 0, 1, 0, 0, 0);
    cy("refill_u",    0, U,        0, 0, 0, 0,   D, 0, 0, 1, 0, 0, 1);
    cy("push_pop",    0, R,        0, 0, 0, 1,   L, 1, 0, 1, 0, 0, 1);
    cy("multihot",    0, 4'b0101,  0, 0, 0, 0,   L, 0, 0, 1, 0, 0, 1);
    cy("pop_u2",      0, N,        0, 0, 0, 1,   U, 1, 0, 1, 0, 0, 0);
    cy("pop_r2",      0, N,        0, 0, 0, 1,   R, 1, 0, 1, 0, 0, 0);
    cy("drained",     0, N,        0, 0, 0, 1,   R, 1, 0, 1, 0, 0, 0);
    // scoring and saturation of the narrow instance
    cy("good1",       0, N,        0, 1, 0, 0,   R, 0, 1, 1, 1, 1, 0);
    cy("quiet3",      0, N,        0, 0, 0, 0,   R, 0, 0, 1, 1, 1, 0);
    cy("good2",       0, N,        0, 1, 0, 0,   R, 0, 1, 1, 2, 2, 0);
    cy("good3",       0, N,        0, 1, 0, 0,   R, 0, 1, 1, 3, 3, 0);
    cy("good4",       0, N,        0, 1, 0, 0,   R, 0, 1, 1, 4, 3, 0);
    cy("good5",       0, N,        0, 1, 0, 0,   R, 0, 1, 1, 5, 3, 0);
    // pause holds everything, still accepts turns
    cy("pause",       0, N,        1, 0, 0, 0,   R, 0, 0, 2, 5, 3, 0);
    cy("pause_tick",  0, N,        0, 0, 0, 1,   R, 0, 0, 2, 5, 3, 0);
    cy("pause_good",  0, N,        0, 1, 0, 0,   R, 0, 0, 2, 5, 3, 0);
    cy("pause_bad",   0, N,        0, 0, 1, 0,   R, 0, 0, 2, 5, 3, 0);
    cy("pause_push",  0, U,        0, 0, 0, 0,   R, 0, 0, 2, 5, 3, 0);
    cy("resume",      0, N,        1, 0, 0, 0,   R, 0, 0, 1, 5, 3, 0);
    cy("pop_paused",  0, N,        0, 0, 0, 1,   U, 1, 0, 1, 5, 3, 0);
    // simultaneous collisions: game over, no grow
    cy("good_bad",    0, N,        0, 1, 1, 0,   U, 0, 0, 3, 5, 3, 0);
    cy("over_tick",   0, N,        0, 0, 0, 1,   U, 0, 0, 3, 5, 3, 0);
    cy("over_good",   0, N,        0, 1, 0, 0,   U, 0, 0, 3, 5, 3, 0);
    cy("to_idle",     0, N,        1, 0, 0, 0,   U, 0, 0, 0, 5, 3, 0);
    cy("restart",     0, N,        1, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    // reset while a step is pending and inputs are active
    cy("pre_rst_u",   0, U,        0, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    cy("pre_rst_tk",  0, N,        0, 1, 0, 1,   U, 1, 1, 1, 1, 1, 0);
    cy("mid_rst",     1, L,        0, 1, 0, 1,   R, 0, 0, 0, 0, 0, 0);
    cy("post_start",  0, N,        1, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    cy("post_tick",   0, N,        0, 0, 0, 1,   R, 1, 0, 1, 0, 0, 0);
    // button and bad collision together: game over wins, queued turn flushed
    cy("q_before",    0, D,        0, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    cy("btn_bad",     0, N,        1, 0, 1, 1,   R, 0, 0, 3, 0, 0, 0);
    cy("ov_idle",     0, N,        1, 0, 0, 0,   R, 0, 0, 0, 0, 0, 0);
    cy("ov_run",      0, N,        1, 0, 0, 0,   R, 0, 0, 1, 0, 0, 0);
    cy("flushed",     0, N,        0, 0, 0, 1,   R, 1, 0, 1, 0, 0, 0);

    tests_run++;
    assert (sb_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
